bram_note_sequencer: RTL

// Song playback stage downstream of the note-storage BRAM. Walks BRAM addresses, issues
// one read per note, decodes each 8-bit entry into pitch + duration, drives a square

---
 rtl/bram_note_sequencer.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/bram_note_sequencer.sv
// -----------------------------------------------------------------------------
// bram_note_sequencer
// Song playback stage that sits behind the note-storage BRAM. It walks the BRAM
// addresses and issues one read per note. It decodes each 8-bit entry
// {pitch[7:4], dur[3:0]}, plays a square wave on the speaker pin for dur beats,
// and exports the current pitch to the 7-segment path.
//
// Ports
//   i_Clk      system clock (25 MHz; the tone table assumes this)
//   i_Rst      asynchronous, active-high reset
//   i_Play     level: 1 = play, 0 = stop and return to IDLE at address 0
//   o_Rd_En    BRAM read enable (one-cycle pulse per note)
//   o_R_Addr   BRAM read address
//   i_Rd_Data  BRAM read data, valid the cycle after o_Rd_En
//   o_Speaker  square-wave audio output
//   o_Note     current pitch index during PLAY, else 0
//   o_Busy     1 while fetching, latching or playing a note
// -----------------------------------------------------------------------------
module bram_note_sequencer #(
    parameter int Addr_Width    = 4,
    parameter int Data_Width    = 8,
    parameter int CLKS_PER_BEAT = 6250000,
    parameter int LOOP          = 0
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic                  i_Play,
    output logic                  o_Rd_En,
    output logic [Addr_Width-1:0] o_R_Addr,
    input  logic [Data_Width-1:0] i_Rd_Data,
    output logic                  o_Speaker,
    output logic [3:0]            o_Note,
    output logic                  o_Busy
);

    // One extra bit keeps the beat counter clear of overflow at every legal CLKS_PER_BEAT.
    localparam int                  BEAT_W    = $clog2(CLKS_PER_BEAT) + 1;
    localparam logic [BEAT_W-1:0]   BEAT_LAST = BEAT_W'(CLKS_PER_BEAT - 1);
    localparam logic [Addr_Width-1:0] ADDR_ONE = Addr_Width'(1'b1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LATCH = 3'd2,
        S_PLAY  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Half period in clocks for pitch 1..15 (C4..D5 at 25 MHz); pitch 0 is a rest.
    function automatic logic [15:0] half_period(input logic [3:0] pitch);
        logic [15:0] h;
        case (pitch)
            4'd1:    h = 16'd47777;
            4'd2:    h = 16'd45097;
            4'd3:    h = 16'd42566;
            4'd4:    h = 16'd40176;
            4'd5:    h = 16'd37921;
            4'd6:    h = 16'd35793;
            4'd7:    h = 16'd33785;
            4'd8:    h = 16'd31888;
            4'd9:    h = 16'd30099;
            4'd10:   h = 16'd28409;
            4'd11:   h = 16'd26815;
            4'd12:   h = 16'd25310;
            4'd13:   h = 16'd23889;
            4'd14:   h = 16'd22548;
            4'd15:   h = 16'd21283;
            default: h = 16'd1;
        endcase
        return h;
    endfunction

    state_t                  state_r;
    logic [Addr_Width-1:0]   addr_r;
    logic [3:0]              pitch_r;
    logic [3:0]              beats_r;
    logic [BEAT_W-1:0]       beat_cnt_r;
    logic [15:0]             tone_cnt_r;
    logic                    rd_en_r;
    logic                    speaker_r;
    logic [3:0]              note_r;
    logic                    busy_r;

    logic [3:0]              rd_pitch_s;
    logic [3:0]              rd_dur_s;
    logic [15:0]             tone_last_s;
    logic                    beat_end_s;
    logic                    note_end_s;

    // Entry field split, tone wrap point and end-of-note detection.
    always_comb begin
        rd_pitch_s  = i_Rd_Data[7:4];
        rd_dur_s    = i_Rd_Data[3:0];
        tone_last_s = half_period(pitch_r) - 16'd1;
        beat_end_s  = (beat_cnt_r == BEAT_LAST);
        note_end_s  = beat_end_s && (beats_r == 4'd1);
    end

    // Sequencer FSM with registered outputs; i_Play low overrides every state.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_r    <= S_IDLE;
            addr_r     <= '0;
            pitch_r    <= 4'd0;
            beats_r    <= 4'd0;
            beat_cnt_r <= '0;
            tone_cnt_r <= 16'd0;
            rd_en_r    <= 1'b0;
            speaker_r  <= 1'b0;
            note_r     <= 4'd0;
            busy_r     <= 1'b0;
        end else if (!i_Play) begin
            state_r    <= S_IDLE;
            addr_r     <= '0;
            beat_cnt_r <= '0;
            tone_cnt_r <= 16'd0;
            rd_en_r    <= 1'b0;
            speaker_r  <= 1'b0;
            note_r     <= 4'd0;
            busy_r     <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    state_r <= S_FETCH;
                    addr_r  <= '0;
                    rd_en_r <= 1'b1;
                    busy_r  <= 1'b1;
                end
                S_FETCH: begin
                    state_r <= S_LATCH;
                    rd_en_r <= 1'b0;
                end
                S_LATCH: begin
                    pitch_r    <= rd_pitch_s;
                    beats_r    <= rd_dur_s;
                    beat_cnt_r <= '0;
                    tone_cnt_r <= 16'd0;
                    speaker_r  <= 1'b0;
                    if (rd_dur_s == 4'd0) begin
                        // Zero duration marks the end of the song.
                        if (LOOP != 0) begin
                            state_r <= S_FETCH;
                            addr_r  <= '0;
                            rd_en_r <= 1'b1;
                        end else begin
                            state_r <= S_DONE;
                            busy_r  <= 1'b0;
                        end
                    end else begin
                        state_r <= S_PLAY;
                        note_r  <= rd_pitch_s;
                    end
                end
                S_PLAY: begin
                    // Tone generator: toggle every H clocks; rests stay silent.
                    if (pitch_r == 4'd0) begin
                        speaker_r  <= 1'b0;
                        tone_cnt_r <= 16'd0;
                    end else if (tone_cnt_r == tone_last_s) begin
                        speaker_r  <= ~speaker_r;
                        tone_cnt_r <= 16'd0;
                    end else begin
                        tone_cnt_r <= tone_cnt_r + 16'd1;
                    end
                    // Beat timing: dur beats of CLKS_PER_BEAT clocks each.
                    if (beat_end_s) begin
                        beat_cnt_r <= '0;
                        beats_r    <= beats_r - 4'd1;
                    end else begin
                        beat_cnt_r <= beat_cnt_r + BEAT_W'(1'b1);
                    end
                    if (note_end_s) begin
                        state_r    <= S_FETCH;
                        addr_r     <= addr_r + ADDR_ONE;
                        rd_en_r    <= 1'b1;
                        note_r     <= 4'd0;
                        speaker_r  <= 1'b0;
                        tone_cnt_r <= 16'd0;
                    end
                end
                S_DONE: begin
                    state_r <= S_DONE;
                    rd_en_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r   <= S_IDLE;
                    addr_r    <= '0;
                    rd_en_r   <= 1'b0;
                    speaker_r <= 1'b0;
                    note_r    <= 4'd0;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    assign o_Rd_En   = rd_en_r;
    assign o_R_Addr  = addr_r;
    assign o_Speaker = speaker_r;
    assign o_Note    = note_r;
    assign o_Busy    = busy_r;

endmodule
